mm_burst_gen: RTL and testbench
===============================

MM_BURST_GEN -- requirements
Module: mm_burst_gen

Interface
REQ-001 Parameter PATTERN_BASE, default 32'hA5A5_0000: base word for the generated write-data pattern.
REQ-002 Port clk  in  1  clock; all logic is rising-edge.
REQ-003 Port rst_n  in  1  reset, synchronous, active-low.
REQ-004 Ports cmd_wr / cmd_rd  in  1/1  single-cycle start pulses for a write or read burst.
REQ-005 Ports cmd_len / cmd_burst / cmd_size / cmd_addr  in  8/2/3/32  burst length-1, burst type, beat size, start address; sampled only on an accepted pulse.
REQ-006 Ports awaddr / awlen / awsize / awburst / awvalid  out  32/8/3/2/1  AXI4 write-address channel; awready  in  1.
REQ-007 Ports wdata / wstrb / wlast / wvalid  out  128/16/1/1  AXI4 write-data channel; wready  in  1.
REQ-008 Ports bresp / bvalid  in  2/1  and bready  out  1  AXI4 write-response channel.
REQ-009 Ports araddr / arlen / arsize / arburst / arvalid  out  32/8/3/2/1  AXI4 read-address channel; arready  in  1.
REQ-010 Ports rdata / rresp / rlast / rvalid  in  128/2/1/1  and rready  out  1  AXI4 read-data channel.
REQ-011 Ports write_complete / read_complete / resp_err / busy  out  1 each  status.
REQ-012 Ports data_out_first, data_out_last, data_in_first, data_in_last  out  128 each, each with a 1-bit *_valid strobe  out  1: captured beats.

Function
REQ-013 FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA; busy = (state != IDLE).
REQ-014 In IDLE, cmd_wr -> WR_ADDR and cmd_rd -> RD_ADDR; if both are high, the write wins and the read is discarded.
REQ-015 On an accepted command, latch the cmd_* fields, clear the beat counter, and clear write_complete, read_complete and resp_err.
REQ-016 A cmd_wr or cmd_rd pulse outside IDLE is ignored, with no state change.
REQ-017 WR_ADDR: awvalid=1 with the latched fields; stays high until awready; on handshake -> WR_DATA.
REQ-018 WR_DATA: wvalid=1, wstrb=16'hFFFF, wdata = 4 copies of (PATTERN_BASE + beat), with 32-bit modulo add; beat increments on each wvalid&wready.
REQ-019 wlast=1 exactly when beat==latched len; the last-beat handshake -> WR_RESP; total beats = len+1 (1..256).
REQ-020 wdata and wvalid hold stable while wready=0.
REQ-021 WR_RESP: bready=1; on bvalid handshake set write_complete, set resp_err if bresp!=0, then -> IDLE.
REQ-022 RD_ADDR: arvalid=1 with the latched fields until arready; on handshake -> RD_DATA.
REQ-023 RD_DATA: rready=1; beat increments on each rvalid&rready; on the rlast handshake set read_complete and -> IDLE.
REQ-024 Read errors: resp_err is set if any rresp!=0, if rlast arrives with beat!=len, or if beat==len is accepted without rlast.
REQ-025 In the last case of REQ-024 the FSM keeps waiting for rlast.
REQ-026 data_out_first / _valid: loaded with wdata, valid pulsed for 1 cycle, on the beat-0 W handshake.
REQ-027 data_out_last / _valid: loaded with wdata, valid pulsed for 1 cycle, on the wlast W handshake.
REQ-028 data_in_first / _valid and data_in_last / _valid: the same capture from rdata on the beat-0 and rlast R handshakes.
REQ-029 For len=0, the first and last captures occur in the same cycle with identical data.
REQ-030 Captured data holds until the next capture.
REQ-031 write_complete, read_complete and resp_err are sticky levels, cleared only per REQ-015 or by reset.
REQ-032 The beat counter is 8 bits; it does not wrap within a legal burst.
REQ-033 Latency: awvalid / arvalid assert the cycle after the accepted command pulse; a zero-wait-state slave completes a write in len+4 cycles.

Reset
REQ-034 While rst_n=0 at a clk edge, the FSM goes to IDLE.
REQ-035 Reset also clears to 0: all valid/ready outputs, wlast, busy, status outputs, *_valid strobes, captured data, beat counter and latched fields.
REQ-036 Reset mid-burst abandons the transaction: all valids are low the cycle after the reset edge, with no completion flag set.

Verification
REQ-037 Write, len=3, addr=0x100, INCR, size=4, slave always ready -> 4 W beats with words A5A50000..A5A50003 and wlast on the 4th beat; bresp=0 -> write_complete=1, resp_err=0.
REQ-038 Read, len=0, rdata=0xDEAD.., rlast=1 -> data_in_first_valid and data_in_last_valid pulse together, read_complete=1.
REQ-039 Backpressure: wready toggling 1/0 with len=7 -> wdata is stable while stalled, exactly 8 handshakes, data_out_last = A5A50007 x4.
REQ-040 Errors: bresp=2'b10 -> resp_err=1; a read with rlast on beat 2 when len=3 -> resp_err=1 and read_complete=1.
REQ-041 Concurrency: cmd_wr and cmd_rd together in IDLE -> only AW issued; cmd_rd pulsed during WR_DATA -> ignored, with no AR afterwards.
REQ-042 Reset asserted in WR_DATA beat 2 -> next cycle wvalid=0, busy=0, write_complete=0.

Source files
------------

// File: rtl/mm_burst_gen.sv
// mm_burst_gen: single-outstanding AXI4 burst master. It issues one write or
// read burst per command, generates the write data pattern, checks the
// read/write responses and captures the first and last beat of each burst.
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_wr/cmd_rd, cmd_*             start pulses and burst descriptor
//   aw*/w*/b*                        AXI4 write address/data/response
//   ar*/r*                           AXI4 read address/data
//   write_complete/read_complete     sticky completion flags
//   resp_err, busy                   sticky error flag, transaction active
//   data_out_*/data_in_*             captured first/last write/read beats
module mm_burst_gen #(
  parameter logic [31:0] PATTERN_BASE = 32'hA5A5_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_wr,
  input  logic         cmd_rd,
  input  logic [7:0]   cmd_len,
  input  logic [1:0]   cmd_burst,
  input  logic [2:0]   cmd_size,
  input  logic [31:0]  cmd_addr,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [127:0] wdata,
  output logic [15:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic         write_complete,
  output logic         read_complete,
  output logic         resp_err,
  output logic         busy,
  output logic [127:0] data_out_first,
  output logic         data_out_first_valid,
  output logic [127:0] data_out_last,
  output logic         data_out_last_valid,
  output logic [127:0] data_in_first,
  output logic         data_in_first_valid,
  output logic [127:0] data_in_last,
  output logic         data_in_last_valid
);

  localparam int unsigned DW    = 128;
  localparam int unsigned LW    = 8;
  localparam int unsigned WORDS = DW / 32;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   beat, beat_n;
  logic [LW-1:0]   len_q, len_n;
  logic [1:0]      burst_q, burst_n;
  logic [2:0]      size_q, size_n;
  logic [31:0]     addr_q, addr_n;
  logic            awvalid_n, wvalid_n, wlast_n, bready_n, arvalid_n, rready_n;
  logic [DW-1:0]   wdata_n;
  logic            wc_n, rc_n, err_n;
  logic [DW-1:0]   dof_n, dol_n, dif_n, dil_n;
  logic            dofv_n, dolv_n, difv_n, dilv_n;

  // Write pattern: every 32-bit lane carries PATTERN_BASE + beat (mod 2^32)
  function automatic logic [DW-1:0] pattern(input logic [LW-1:0] b);
    return {WORDS{PATTERN_BASE + 32'(b)}};
  endfunction

  // Address channels share the latched descriptor
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = burst_q;
  assign wstrb   = {16{wvalid}};

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      beat                 <= '0;
      len_q                <= '0;
      burst_q              <= '0;
      size_q               <= '0;
      addr_q               <= '0;
      awvalid              <= 1'b0;
      wvalid               <= 1'b0;
      wlast                <= 1'b0;
      wdata                <= '0;
      bready               <= 1'b0;
      arvalid              <= 1'b0;
      rready               <= 1'b0;
      write_complete       <= 1'b0;
      read_complete        <= 1'b0;
      resp_err             <= 1'b0;
      busy                 <= 1'b0;
      data_out_first       <= '0;
      data_out_first_valid <= 1'b0;
      data_out_last        <= '0;
      data_out_last_valid  <= 1'b0;
      data_in_first        <= '0;
      data_in_first_valid  <= 1'b0;
      data_in_last         <= '0;
      data_in_last_valid   <= 1'b0;
    end else begin
      state                <= state_n;
      beat                 <= beat_n;
      len_q                <= len_n;
      burst_q              <= burst_n;
      size_q               <= size_n;
      addr_q               <= addr_n;
      awvalid              <= awvalid_n;
      wvalid               <= wvalid_n;
      wlast                <= wlast_n;
      wdata                <= wdata_n;
      bready               <= bready_n;
      arvalid              <= arvalid_n;
      rready               <= rready_n;
      write_complete       <= wc_n;
      read_complete        <= rc_n;
      resp_err             <= err_n;
      busy                 <= (state_n != IDLE);
      data_out_first       <= dof_n;
      data_out_first_valid <= dofv_n;
      data_out_last        <= dol_n;
      data_out_last_valid  <= dolv_n;
      data_in_first        <= dif_n;
      data_in_first_valid  <= difv_n;
      data_in_last         <= dil_n;
      data_in_last_valid   <= dilv_n;
    end
  end

  // Next state, counters, status and captures
  always_comb begin
    state_n = state;
    beat_n  = beat;
    len_n   = len_q;
    burst_n = burst_q;
    size_n  = size_q;
    addr_n  = addr_q;
    wc_n    = write_complete;
    rc_n    = read_complete;
    err_n   = resp_err;
    dof_n   = data_out_first;
    dol_n   = data_out_last;
    dif_n   = data_in_first;
    dil_n   = data_in_last;
    dofv_n  = 1'b0;
    dolv_n  = 1'b0;
    difv_n  = 1'b0;
    dilv_n  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_wr || cmd_rd) begin
          len_n   = cmd_len;
          burst_n = cmd_burst;
          size_n  = cmd_size;
          addr_n  = cmd_addr;
          beat_n  = '0;
          wc_n    = 1'b0;
          rc_n    = 1'b0;
          err_n   = 1'b0;
          state_n = cmd_wr ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: if (awvalid && awready) state_n = WR_DATA;
      WR_DATA: begin
        if (wvalid && wready) begin
          if (beat == '0) begin
            dof_n  = wdata;
            dofv_n = 1'b1;
          end
          if (wlast) begin
            dol_n   = wdata;
            dolv_n  = 1'b1;
            state_n = WR_RESP;
          end else begin
            beat_n = beat + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (bready && bvalid) begin
          wc_n    = 1'b1;
          err_n   = resp_err | (bresp != 2'b00);
          state_n = IDLE;
        end
      end
      RD_ADDR: if (arvalid && arready) state_n = RD_DATA;
      RD_DATA: begin
        if (rvalid && rready) begin
          if (rresp != 2'b00) err_n = 1'b1;
          if (beat == '0) begin
            dif_n  = rdata;
            difv_n = 1'b1;
          end
          if (rlast) begin
            if (beat != len_q) err_n = 1'b1;
            dil_n   = rdata;
            dilv_n  = 1'b1;
            rc_n    = 1'b1;
            state_n = IDLE;
          end else begin
            // Slave overran the length: flag it but keep waiting for rlast
            if (beat == len_q) err_n = 1'b1;
            beat_n = beat + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Registered channel outputs follow the state being entered
    awvalid_n = (state_n == WR_ADDR);
    wvalid_n  = (state_n == WR_DATA);
    wlast_n   = wvalid_n && (beat_n == len_n);
    wdata_n   = wvalid_n ? pattern(beat_n) : wdata;
    bready_n  = (state_n == WR_RESP);
    arvalid_n = (state_n == RD_ADDR);
    rready_n  = (state_n == RD_DATA);
  end

endmodule

// File: tb/tb_mm_burst_gen.sv
// Self-checking bench for mm_burst_gen: a bench-driven AXI slave with a
// scoreboard of expected W beats and read captures checked by a monitor.
module tb_mm_burst_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_wr, cmd_rd;
  logic [7:0]   cmd_len;
  logic [1:0]   cmd_burst;
  logic [2:0]   cmd_size;
  logic [31:0]  cmd_addr;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst;
  logic         awvalid, awready, arvalid, arready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, rlast, rvalid, rready;
  logic         write_complete, read_complete, resp_err, busy;
  logic [127:0] data_out_first, data_out_last, data_in_first, data_in_last;
  logic         data_out_first_valid, data_out_last_valid;
  logic         data_in_first_valid, data_in_last_valid;

  mm_burst_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .write_complete(write_complete), .read_complete(read_complete),
    .resp_err(resp_err), .busy(busy),
    .data_out_first(data_out_first), .data_out_first_valid(data_out_first_valid),
    .data_out_last(data_out_last), .data_out_last_valid(data_out_last_valid),
    .data_in_first(data_in_first), .data_in_first_valid(data_in_first_valid),
    .data_in_last(data_in_last), .data_in_last_valid(data_in_last_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } wbeat_t;

  wbeat_t       exp_w[$];
  logic [127:0] exp_dif[$];
  logic [127:0] exp_dil[$];

  int n_tests = 0;
  int n_fail  = 0;
  int w_hs_cnt = 0, aw_cnt = 0, ar_cnt = 0;
  int dof_cnt = 0, dol_cnt = 0, rboth_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [127:0] wdata_prev = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] wpat(input int b);
    return {4{32'hA5A5_0000 + 32'(b)}};
  endfunction

  function automatic logic [127:0] rpat(input int b);
    return {4{32'hDEAD_0000 + 32'(b)}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, where all handshake signals are settled
  always @(negedge clk) begin
    if (wvalid && wready) begin
      w_hs_cnt++;
      if (exp_w.size() == 0) check("w_extra", 128'(1), 128'(0));
      else begin
        wbeat_t e;
        e = exp_w.pop_front();
        check("wdata", wdata, e.d);
        check("wlast", 128'(wlast), 128'(e.l));
      end
    end
    if (stall_prev && wvalid) check("w_stable", wdata, wdata_prev);
    stall_prev = wvalid && !wready;
    wdata_prev = wdata;
    if (awvalid && awready) aw_cnt++;
    if (arvalid && arready) ar_cnt++;
    if (data_out_first_valid) dof_cnt++;
    if (data_out_last_valid) dol_cnt++;
    if (data_in_first_valid && data_in_last_valid) rboth_cnt++;
    if (data_in_first_valid) begin
      if (exp_dif.size() == 0) check("dif_extra", 128'(1), 128'(0));
      else check("data_in_first", data_in_first, exp_dif.pop_front());
    end
    if (data_in_last_valid) begin
      if (exp_dil.size() == 0) check("dil_extra", 128'(1), 128'(0));
      else check("data_in_last", data_in_last, exp_dil.pop_front());
    end
  end

  task automatic do_write(input int len, input logic [1:0] br, input bit toggle,
                          input bit both, input bit rd_mid, input int rst_after);
    int aw0, ar0, wh0, dof0, dol0, cycles;
    bit done;
    for (int i = 0; i <= len; i++) exp_w.push_back('{wpat(i), (i == len)});
    aw0 = aw_cnt; ar0 = ar_cnt; wh0 = w_hs_cnt; dof0 = dof_cnt; dol0 = dol_cnt;
    cmd_wr = 1'b1; cmd_rd = both; cmd_len = 8'(len); cmd_addr = 32'h100;
    cmd_burst = 2'b01; cmd_size = 3'd4;
    tick;
    cmd_wr = 1'b0; cmd_rd = 1'b0;
    check("aw_latency", 128'(awvalid), 128'(1));
    check("awaddr", 128'(awaddr), 128'(32'h100));
    check("awlen", 128'(awlen), 128'(len));
    check("wc_cleared", 128'(write_complete), 128'(0));
    done = 1'b0; cycles = 0;
    for (int n = 1; n <= 600 && !done; n++) begin
      awready = 1'b1;
      wready  = toggle ? n[0] : 1'b1;
      bvalid  = 1'b1;
      bresp   = br;
      cmd_rd  = rd_mid && (n == 3);
      if (rst_after > 0 && (w_hs_cnt - wh0) == rst_after) begin
        wready = 1'b0;
        rst_n  = 1'b0;
        tick;
        rst_n  = 1'b1;
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wc", 128'(write_complete), 128'(0));
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_dof", data_out_first, 128'(0));
        exp_w.delete();
        awready = 1'b0; bvalid = 1'b0;
        return;
      end
      tick;
      cmd_rd = 1'b0;
      if (write_complete) begin
        done = 1'b1;
        cycles = n;
      end
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    check("wr_done", 128'(done), 128'(1));
    check("resp_err_w", 128'(resp_err), 128'(br != 2'b00));
    check("busy_end_w", 128'(busy), 128'(0));
    check("w_hs_count", 128'(w_hs_cnt - wh0), 128'(len + 1));
    check("w_left", 128'(exp_w.size()), 128'(0));
    check("dout_first", data_out_first, wpat(0));
    check("dout_last", data_out_last, wpat(len));
    check("dof_pulses", 128'(dof_cnt - dof0), 128'(1));
    check("dol_pulses", 128'(dol_cnt - dol0), 128'(1));
    if (!toggle) check("wr_latency", 128'(cycles), 128'(len + 3));
    tick; tick; tick;
    check("aw_count", 128'(aw_cnt - aw0), 128'(1));
    check("no_ar", 128'(ar_cnt - ar0), 128'(0));
    check("idle_after_w", 128'(busy), 128'(0));
  endtask

  task automatic do_read(input int len, input int last_at, input int err_beat, input bit exp_err);
    int ar0, aw0, rb0, k;
    bit done, hs;
    exp_dif.push_back(rpat(0));
    exp_dil.push_back(rpat(last_at));
    ar0 = ar_cnt; aw0 = aw_cnt; rb0 = rboth_cnt;
    cmd_rd = 1'b1; cmd_len = 8'(len); cmd_addr = 32'h2000;
    cmd_burst = 2'b01; cmd_size = 3'd4;
    tick;
    cmd_rd = 1'b0;
    check("ar_latency", 128'(arvalid), 128'(1));
    check("araddr", 128'(araddr), 128'(32'h2000));
    check("rc_cleared", 128'(read_complete), 128'(0));
    done = 1'b0; k = 0;
    for (int n = 1; n <= 600 && !done; n++) begin
      arready = 1'b1;
      rvalid  = 1'b1;
      rdata   = rpat(k);
      rlast   = (k == last_at);
      rresp   = (k == err_beat) ? 2'b10 : 2'b00;
      hs      = rready;
      tick;
      if (hs) k++;
      if (read_complete) done = 1'b1;
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("rd_done", 128'(done), 128'(1));
    check("resp_err_r", 128'(resp_err), 128'(exp_err));
    check("busy_end_r", 128'(busy), 128'(0));
    check("rready_low", 128'(rready), 128'(0));
    tick;
    check("dif_left", 128'(exp_dif.size()), 128'(0));
    check("dil_left", 128'(exp_dil.size()), 128'(0));
    check("din_first_hold", data_in_first, rpat(0));
    check("din_last_hold", data_in_last, rpat(last_at));
    check("r_same_cycle", 128'(rboth_cnt - rb0), 128'(last_at == 0));
    check("ar_count", 128'(ar_cnt - ar0), 128'(1));
    check("no_aw", 128'(aw_cnt - aw0), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_wr = 1'b0; cmd_rd = 1'b0; cmd_len = '0; cmd_burst = '0; cmd_size = '0; cmd_addr = '0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0; arready = 1'b0;
    rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    tick; tick;
    check("rst_awvalid0", 128'(awvalid), 128'(0));
    check("rst_wvalid0", 128'(wvalid), 128'(0));
    check("rst_arvalid0", 128'(arvalid), 128'(0));
    check("rst_ready0", 128'({bready, rready, wlast}), 128'(0));
    check("rst_status0", 128'({busy, write_complete, read_complete, resp_err}), 128'(0));
    check("rst_capt0", data_out_last | data_in_first, 128'(0));
    rst_n = 1'b1;
    tick;

    do_write(3, 2'b00, 1'b0, 1'b0, 1'b0, 0);   // basic INCR write
    do_read(0, 0, -1, 1'b0);                   // single-beat read
    do_write(7, 2'b00, 1'b1, 1'b0, 1'b0, 0);   // wready backpressure
    do_write(0, 2'b10, 1'b0, 1'b0, 1'b0, 0);   // SLVERR on B
    do_read(3, 2, -1, 1'b1);                   // early rlast
    do_read(3, 3, 1, 1'b1);                    // bad rresp mid-burst
    do_write(2, 2'b00, 1'b0, 1'b1, 1'b0, 0);   // wr+rd together: write wins
    do_write(7, 2'b00, 1'b0, 1'b0, 1'b1, 0);   // rd pulse during WR_DATA
    do_read(1, 2, -1, 1'b1);                   // overrun: late rlast
    do_write(7, 2'b00, 1'b0, 1'b0, 1'b0, 2);   // reset mid-burst
    do_read(2, 2, -1, 1'b0);                   // clean read after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
